azadi_irq_ctrl: RTL and testbench
=================================

// Module: azadi_irq_ctrl
// PURPOSE
//  Interrupt source side of the core trap interface: samples software/timer/external/fast/NMI lines,
//  holds pending state (mip), masks with mie + global enable, arbitrates, and issues one request
//  with an exc_cause_e-encoded cause to the core controller, held until acknowledged.
//  Sits between SoC interrupt sources and the core controller/CSR file.
// PARAMETERS
//  FastEdgeMask  15'h7fff  bit i=1: irq_fast[i] edge-triggered (latched until ack); 0: level
//  NmEdge        1'b1      1: irq_nm_i rising edge latched until ack; 0: level
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   reset, synchronous, active-high
//  irq_software_i  in   1   machine software irq (level)
//  irq_timer_i     in   1   machine timer irq (level)
//  irq_external_i  in   1   machine external irq (level)
//  irq_fast_i      in   15  fast irqs
//  irq_nm_i        in   1   non-maskable irq
//  mie_i           in   18  enables, irqs_t layout {sw,timer,ext,fast[14:0]}
//  mstatus_mie_i   in   1   global enable (NMI ignores it)
//  irq_ack_i       in   1   core accepted current request
//  mip_o           out  18  pending, irqs_t layout
//  nmi_pending_o   out  1   NMI pending
//  irq_req_o       out  1   request to core
//  irq_cause_o     out  6   exc_cause_e of request; MSB=1
// BEHAVIOUR
//  - Reset: mip_o=0, nmi_pending_o=0, irq_req_o=0, irq_cause_o=6'h00, edge history=0, FSM IDLE.
//  - Pending: level bits = registered copy of input; edge bits set on 0->1 of input, cleared only
//    on ack of that cause (set wins over clear if new edge coincides with ack).
//  - Eligible = mip & mie & {18{mstatus_mie_i}}; NMI always eligible.
//  - Priority: NMI > fast[0] > ... > fast[14] > external > software > timer.
//  - Causes: NMI {1,31}; fast[i] {1,16+i}; ext {1,11}; sw {1,3}; timer {1,7}.
//  - Latency: input high before edge k -> mip_o at k -> irq_req_o+cause at k+1.
//  - FSM IDLE: any eligible -> REQ, register winner cause, irq_req_o=1.
//  - FSM REQ: irq_req_o=1, cause frozen (no pre-emption by higher priority).
//    irq_ack_i -> clear latched bit of held cause if edge type; -> ACKD.
//    held level cause no longer eligible (source low or masked) and no ack -> withdraw: IDLE, req=0.
//    NMI request never withdrawn.
//  - FSM ACKD: one cycle, req=0; -> IDLE. Guarantees >=1 idle cycle between requests.
//  - irq_ack_i outside REQ: ignored.
//  - Reset in any state returns to reset values next edge; in-flight request dropped.
// CONFIGURATION
//  AZADI_IRQ_SYNC_EN defined: 2-flop synchroniser on all 19 irq inputs ahead of pending logic;
//   input->mip latency +2 cycles (k+2 mip, k+3 req); sync flops reset to 0.
//  Not defined: inputs assumed synchronous to clk_i; latencies as above.
// TESTING
//  1 timer=1, mie timer=1, mstatus_mie=1 -> req at k+1, cause 6'h27; ack -> req 0, ACKD 1 cycle.
//  2 ext+sw+timer+fast[3] together -> cause 6'h33 (fast3); ack+pulse-only fast -> then ext 6'h2b.
//  3 mstatus_mie=0, irq_nm_i 1-cycle pulse -> req, cause 6'h3f; held until ack; nmi_pending_o clears.
//  4 ext level in REQ, drop irq_external_i before ack -> req 0 next cycle, no ack needed, IDLE.
//  5 fast[0] edge while req held for fast[5] -> cause stays 6'h35 until ack; then 6'h30 after ACKD.
//  6 rst_i mid-REQ -> req 0, mip 0, cause 0 next edge; repeat 1 with AZADI_IRQ_SYNC_EN -> req at k+3.

Source files
------------

// File: rtl/azadi_irq_ctrl_if.sv
// Request/acknowledge handshake between the interrupt controller and the core controller.
// master = interrupt controller (drives the request), slave = core controller (drives the ack).
interface azadi_irq_ctrl_if;
  logic       irq_req;
  logic [5:0] irq_cause;
  logic       irq_ack;

  modport master (output irq_req, output irq_cause, input irq_ack);
  modport slave  (input irq_req, input irq_cause, output irq_ack);
endinterface

// File: rtl/azadi_irq_ctrl.sv
// Interrupt source side of the core trap interface: pending capture, masking, arbitration, request FSM.
// Optional build macro AZADI_IRQ_SYNC_EN adds a 2-flop synchroniser on all 19 irq inputs.
//
//  state | meaning
//  IDLE  | no request outstanding, arbitrate eligible sources
//  REQ   | request held to core with frozen cause, waiting for ack or withdrawal
//  ACKD  | one-cycle gap after ack, request low
module azadi_irq_ctrl #(
  parameter logic [14:0] FastEdgeMask = 15'h7fff,
  parameter bit          NmEdge       = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   irq_software_i,
  input  logic                   irq_timer_i,
  input  logic                   irq_external_i,
  input  logic [14:0]            irq_fast_i,
  input  logic                   irq_nm_i,
  input  logic [17:0]            mie_i,
  input  logic                   mstatus_mie_i,
  output logic [17:0]            mip_o,
  output logic                   nmi_pending_o,
  azadi_irq_ctrl_if.master       core
);

  localparam logic [5:0] CauseNmi   = 6'h3f;
  localparam logic [5:0] CauseExt   = 6'h2b;
  localparam logic [5:0] CauseSw    = 6'h23;
  localparam logic [5:0] CauseTimer = 6'h27;

  typedef enum logic [1:0] {IDLE, REQ, ACKD} state_e;

  state_e      state_q;
  logic        req_q;
  logic [5:0]  cause_q;

  logic [18:0] irq_raw;
  logic [18:0] irq_s;
  logic [14:0] fast_s;
  logic        nm_s;
  logic [14:0] fast_hist_q;
  logic        nm_hist_q;
  logic [14:0] fast_rise;
  logic        nm_rise;
  logic [17:0] mip_q;
  logic        nmi_q;

  logic [17:0] elig;
  logic [14:0] fast_elig;
  logic        win_valid;
  logic [5:0]  win_cause;
  logic        ack_held;
  logic        is_fast;
  logic [14:0] clr_fast;
  logic        clr_nmi;
  logic        held_level;
  logic        held_elig;

  // {nm, sw, timer, ext, fast[14:0]}
  assign irq_raw = {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};

`ifdef AZADI_IRQ_SYNC_EN
  logic [18:0] sync_q1;
  logic [18:0] sync_q2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_raw;
`endif

  assign fast_s    = irq_s[14:0];
  assign nm_s      = irq_s[18];
  assign fast_rise = fast_s & ~fast_hist_q;
  assign nm_rise   = nm_s & ~nm_hist_q;

  // Fast causes are 6'h30 + index; 6'h3f is the NMI, not a fast line.
  assign is_fast  = (cause_q[5:4] == 2'b11) && (cause_q[3:0] != 4'hf);
  assign ack_held = (state_q == REQ) && core.irq_ack;

  always_comb begin
    clr_fast = '0;
    clr_nmi  = 1'b0;
    if (ack_held) begin
      clr_nmi = (cause_q == CauseNmi);
      for (int i = 0; i < 15; i++) begin
        if (is_fast && (cause_q[3:0] == 4'(i))) clr_fast[i] = 1'b1;
      end
    end
  end

  // A new edge in the same cycle as the ack wins over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mip_q       <= '0;
      nmi_q       <= 1'b0;
      fast_hist_q <= '0;
      nm_hist_q   <= 1'b0;
    end else begin
      mip_q[17:15] <= irq_s[17:15];
      for (int i = 0; i < 15; i++) begin
        if (FastEdgeMask[i]) mip_q[i] <= fast_rise[i] | (mip_q[i] & ~clr_fast[i]);
        else                 mip_q[i] <= fast_s[i];
      end
      nmi_q       <= NmEdge ? (nm_rise | (nmi_q & ~clr_nmi)) : nm_s;
      fast_hist_q <= fast_s;
      nm_hist_q   <= nm_s;
    end
  end

  assign elig      = mip_q & mie_i & {18{mstatus_mie_i}};
  assign fast_elig = elig[14:0];

  always_comb begin
    win_valid = 1'b0;
    win_cause = '0;
    if (nmi_q) begin
      win_valid = 1'b1;
      win_cause = CauseNmi;
    end else if (|fast_elig) begin
      win_valid = 1'b1;
      for (int i = 14; i >= 0; i--) begin
        if (fast_elig[i]) win_cause = {2'b11, 4'(i)};
      end
    end else if (elig[15]) begin
      win_valid = 1'b1;
      win_cause = CauseExt;
    end else if (elig[17]) begin
      win_valid = 1'b1;
      win_cause = CauseSw;
    end else if (elig[16]) begin
      win_valid = 1'b1;
      win_cause = CauseTimer;
    end
  end

  // Only level-type held causes may be withdrawn; NMI and latched edges stay until ack.
  always_comb begin
    held_level = 1'b0;
    held_elig  = 1'b0;
    if (is_fast) begin
      held_level = ~FastEdgeMask[cause_q[3:0]];
      held_elig  = fast_elig[cause_q[3:0]];
    end else begin
      case (cause_q)
        CauseExt:   begin held_level = 1'b1; held_elig = elig[15]; end
        CauseSw:    begin held_level = 1'b1; held_elig = elig[17]; end
        CauseTimer: begin held_level = 1'b1; held_elig = elig[16]; end
        default:    begin held_level = 1'b0; held_elig = 1'b0;     end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            cause_q <= win_cause;
          end
        end
        REQ: begin
          if (core.irq_ack) begin
            state_q <= ACKD;
            req_q   <= 1'b0;
          end else if (held_level && !held_elig) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        ACKD: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mip_o          = mip_q;
  assign nmi_pending_o  = nmi_q;
  assign core.irq_req   = req_q;
  assign core.irq_cause = cause_q;

endmodule

// File: tb/tb_azadi_irq_ctrl.sv
// Directed bench for azadi_irq_ctrl: arbitration vector table plus multi-cycle handshake sequences.
module tb_azadi_irq_ctrl;

`ifdef AZADI_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        irq_software_i, irq_timer_i, irq_external_i, irq_nm_i, mstatus_mie_i;
  logic [14:0] irq_fast_i;
  logic [17:0] mie_i;
  logic [17:0] mip_o;
  logic        nmi_pending_o;

  int total = 0;
  int bad   = 0;

  azadi_irq_ctrl_if bus ();

  azadi_irq_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .irq_software_i (irq_software_i),
    .irq_timer_i    (irq_timer_i),
    .irq_external_i (irq_external_i),
    .irq_fast_i     (irq_fast_i),
    .irq_nm_i       (irq_nm_i),
    .mie_i          (mie_i),
    .mstatus_mie_i  (mstatus_mie_i),
    .mip_o          (mip_o),
    .nmi_pending_o  (nmi_pending_o),
    .core           (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        sw;
    logic        timer;
    logic        ext;
    logic [14:0] fast;
    logic        nm;
    logic [17:0] mie;
    logic        mst;
    logic        exp_req;
    logic [5:0]  exp_cause;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0; irq_nm_i = 0;
    irq_fast_i = '0; mie_i = '0; mstatus_mie_i = 0; bus.irq_ack = 0;
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          sw timer ext fast       nm mie        mst req cause
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 15'h0000, 1'b0, 18'h3ffff, 1'b1, 1'b1, 6'h27};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 15'h0008, 1'b0, 18'h3ffff, 1'b1, 1'b1, 6'h33};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 15'h0000, 1'b0, 18'h3ffff, 1'b1, 1'b1, 6'h2b};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 15'h0000, 1'b0, 18'h3ffff, 1'b1, 1'b1, 6'h23};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 15'h4000, 1'b0, 18'h3ffff, 1'b1, 1'b1, 6'h3e};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 15'h4001, 1'b0, 18'h3ffff, 1'b1, 1'b1, 6'h30};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 15'h7fff, 1'b1, 18'h3ffff, 1'b0, 1'b1, 6'h3f};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 15'h0000, 1'b0, 18'h3ffff, 1'b0, 1'b0, 6'h00};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 15'h0000, 1'b0, 18'h10000, 1'b1, 1'b1, 6'h27};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 15'h0020, 1'b0, 18'h08000, 1'b1, 1'b1, 6'h2b};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 18'h3ffff, 1'b1, 1'b0, 6'h00};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 15'h0080, 1'b0, 18'h3ffff, 1'b1, 1'b1, 6'h37};

    do_reset();
    check("reset_mip", 32'(mip_o), 32'h0);
    check("reset_nmi", 32'(nmi_pending_o), 32'h0);
    check("reset_req", 32'(bus.irq_req), 32'h0);
    check("reset_cause", 32'(bus.irq_cause), 32'h0);

    for (int v = 0; v < 12; v++) begin
      do_reset();
      irq_software_i = vecs[v].sw; irq_timer_i = vecs[v].timer; irq_external_i = vecs[v].ext;
      irq_fast_i = vecs[v].fast; irq_nm_i = vecs[v].nm; mie_i = vecs[v].mie;
      mstatus_mie_i = vecs[v].mst;
      repeat (LAT) tick();
      tick();
      check($sformatf("vec%0d_mip", v), 32'(mip_o),
            32'({vecs[v].sw, vecs[v].timer, vecs[v].ext, vecs[v].fast}));
      check($sformatf("vec%0d_nmi", v), 32'(nmi_pending_o), 32'(vecs[v].nm));
      check($sformatf("vec%0d_req_early", v), 32'(bus.irq_req), 32'h0);
      tick();
      check($sformatf("vec%0d_req", v), 32'(bus.irq_req), 32'(vecs[v].exp_req));
      if (vecs[v].exp_req)
        check($sformatf("vec%0d_cause", v), 32'(bus.irq_cause), 32'(vecs[v].exp_cause));
    end

    // timer request, ack, one ACKD cycle, then re-request from still-pending level
    do_reset();
    irq_timer_i = 1; mie_i = 18'h10000; mstatus_mie_i = 1;
    repeat (LAT) tick();
    tick();
    check("t1_req_k", 32'(bus.irq_req), 32'h0);
    tick();
    check("t1_req_k1", 32'(bus.irq_req), 32'h1);
    check("t1_cause", 32'(bus.irq_cause), 32'h27);
    bus.irq_ack = 1;
    tick();
    bus.irq_ack = 0;
    check("t1_ackd_req", 32'(bus.irq_req), 32'h0);
    tick();
    check("t1_idle_req", 32'(bus.irq_req), 32'h0);
    tick();
    check("t1_rereq", 32'(bus.irq_req), 32'h1);

    // fast3 pulse wins, ack clears it, external follows
    do_reset();
    irq_software_i = 1; irq_timer_i = 1; irq_external_i = 1; irq_fast_i = 15'h0008;
    mie_i = 18'h3ffff; mstatus_mie_i = 1;
    repeat (LAT) tick();
    tick();
    irq_fast_i = '0;
    tick();
    check("t2_cause_fast3", 32'(bus.irq_cause), 32'h33);
    check("t2_fast3_latched", 32'(mip_o[3]), 32'h1);
    bus.irq_ack = 1;
    tick();
    bus.irq_ack = 0;
    check("t2_fast3_cleared", 32'(mip_o[3]), 32'h0);
    check("t2_ackd_req", 32'(bus.irq_req), 32'h0);
    tick();
    tick();
    check("t2_req_ext", 32'(bus.irq_req), 32'h1);
    check("t2_cause_ext", 32'(bus.irq_cause), 32'h2b);

    // NMI pulse with global enable off: held until ack
    do_reset();
    irq_nm_i = 1;
    repeat (LAT) tick();
    tick();
    check("t3_nmi_pend", 32'(nmi_pending_o), 32'h1);
    irq_nm_i = 0;
    tick();
    check("t3_req", 32'(bus.irq_req), 32'h1);
    check("t3_cause", 32'(bus.irq_cause), 32'h3f);
    repeat (3 + LAT) tick();
    check("t3_req_held", 32'(bus.irq_req), 32'h1);
    check("t3_nmi_held", 32'(nmi_pending_o), 32'h1);
    bus.irq_ack = 1;
    tick();
    bus.irq_ack = 0;
    check("t3_req_ack", 32'(bus.irq_req), 32'h0);
    check("t3_nmi_clr", 32'(nmi_pending_o), 32'h0);

    // level external withdrawn without ack
    do_reset();
    irq_external_i = 1; mie_i = 18'h3ffff; mstatus_mie_i = 1;
    repeat (LAT) tick();
    tick();
    tick();
    check("t4_cause", 32'(bus.irq_cause), 32'h2b);
    irq_external_i = 0;
    repeat (LAT) tick();
    tick();
    check("t4_mip_drop", 32'(mip_o[15]), 32'h0);
    check("t4_req_still", 32'(bus.irq_req), 32'h1);
    tick();
    check("t4_withdrawn", 32'(bus.irq_req), 32'h0);
    tick();
    check("t4_idle", 32'(bus.irq_req), 32'h0);

    // no pre-emption: fast0 arrives while fast5 is held
    do_reset();
    irq_fast_i = 15'h0020; mie_i = 18'h3ffff; mstatus_mie_i = 1;
    repeat (LAT) tick();
    tick();
    tick();
    check("t5_cause5", 32'(bus.irq_cause), 32'h35);
    irq_fast_i = 15'h0021;
    repeat (LAT + 2) tick();
    check("t5_fast0_pend", 32'(mip_o[0]), 32'h1);
    check("t5_cause_frozen", 32'(bus.irq_cause), 32'h35);
    bus.irq_ack = 1;
    tick();
    bus.irq_ack = 0;
    check("t5_ackd", 32'(bus.irq_req), 32'h0);
    tick();
    tick();
    check("t5_req0", 32'(bus.irq_req), 32'h1);
    check("t5_cause0", 32'(bus.irq_cause), 32'h30);

    // new edge coinciding with ack keeps the bit pending
    do_reset();
    irq_fast_i = 15'h0004; mie_i = 18'h3ffff; mstatus_mie_i = 1;
    repeat (LAT) tick();
    tick();
    irq_fast_i = '0;
    tick();
    check("t6_cause2", 32'(bus.irq_cause), 32'h32);
    irq_fast_i = 15'h0004;
    repeat (LAT) tick();
    bus.irq_ack = 1;
    tick();
    bus.irq_ack = 0;
    check("t6_set_wins", 32'(mip_o[2]), 32'h1);
    check("t6_ackd", 32'(bus.irq_req), 32'h0);
    tick();
    tick();
    check("t6_rereq", 32'(bus.irq_req), 32'h1);

    // ack outside REQ is ignored
    do_reset();
    irq_fast_i = 15'h0010; mstatus_mie_i = 1;
    repeat (LAT) tick();
    tick();
    check("t7_pend", 32'(mip_o[4]), 32'h1);
    bus.irq_ack = 1;
    tick();
    bus.irq_ack = 0;
    check("t7_ack_ignored", 32'(mip_o[4]), 32'h1);
    check("t7_no_req", 32'(bus.irq_req), 32'h0);
    mie_i = 18'h3ffff;
    tick();
    check("t7_req", 32'(bus.irq_req), 32'h1);
    check("t7_cause", 32'(bus.irq_cause), 32'h34);

    // reset mid-request, then timer request again
    do_reset();
    irq_timer_i = 1; mie_i = 18'h10000; mstatus_mie_i = 1;
    repeat (LAT) tick();
    tick();
    tick();
    check("t8_req_before", 32'(bus.irq_req), 32'h1);
    rst_i = 1;
    tick();
    check("t8_rst_req", 32'(bus.irq_req), 32'h0);
    check("t8_rst_mip", 32'(mip_o), 32'h0);
    check("t8_rst_cause", 32'(bus.irq_cause), 32'h0);
    rst_i = 0;
    repeat (LAT) tick();
    tick();
    check("t8_mip_k", 32'(mip_o[16]), 32'h1);
    check("t8_req_k", 32'(bus.irq_req), 32'h0);
    tick();
    check("t8_req_k1", 32'(bus.irq_req), 32'h1);
    check("t8_cause", 32'(bus.irq_cause), 32'h27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
